// File: rtl/matrix_pkg.sv
// rtl/matrix_pkg.sv - shared constants, op codes and state encoding for the matrix op sequencer
package matrix_pkg;

  localparam int MATRIX_W = 200;
  localparam int ADDR_W   = 8;
  localparam int OP_W     = 3;

  localparam logic [OP_W-1:0] OP_ADD       = 3'd0;
  localparam logic [OP_W-1:0] OP_SUB       = 3'd1;
  localparam logic [OP_W-1:0] OP_MUL       = 3'd2;
  localparam logic [OP_W-1:0] OP_SCALAR    = 3'd3;
  localparam logic [OP_W-1:0] OP_TRANSPOSE = 3'd4;
  localparam logic [OP_W-1:0] OP_OPPOSITE  = 3'd5;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_RD_A      = 3'd1,
    ST_RD_B      = 3'd2,
    ST_EXEC      = 3'd3,
    ST_WAIT_DONE = 3'd4,
    ST_WRITE     = 3'd5,
    ST_FINISH    = 3'd6
  } state_t;

  // Codes 6 and 7 are unassigned and are rejected without touching the RAM.
  function automatic logic op_is_valid(input logic [OP_W-1:0] op);
    return (op <= OP_OPPOSITE);
  endfunction

  // Unary ops only need the A operand.
  function automatic logic op_skips_b(input logic [OP_W-1:0] op);
    return (op == OP_TRANSPOSE) || (op == OP_OPPOSITE);
  endfunction

endpackage

// File: rtl/seq_wait_counter.sv
// rtl/seq_wait_counter.sv - loadable down-counter with zero flag for read-latency and timeout waits
module seq_wait_counter #(
  parameter int WIDTH = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             dec,
  output logic             zero
);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  // Load has priority; decrement saturates at zero.
  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = load_value;
    end else if (dec && (count_q != '0)) begin
      count_d = count_q - 1'b1;
    end
  end

  // Count register.
  always_ff @(posedge clock) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign zero = (count_q == '0);

endmodule

// File: rtl/matrix_op_sequencer.sv
// rtl/matrix_op_sequencer.sv - sequences RAM reads, ALU execution and result write; MATRIX_SEQ_TIMEOUT_EN enables alu_done timeout
module matrix_op_sequencer
  import matrix_pkg::*;
#(
  parameter int READ_LATENCY = 2,
  parameter int TIMEOUT      = 255
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                op_valid,
  input  logic [OP_W-1:0]     op_code,
  input  logic [ADDR_W-1:0]   src_a_addr,
  input  logic [ADDR_W-1:0]   src_b_addr,
  input  logic [ADDR_W-1:0]   dst_addr,
  output logic                op_ready,
  output logic [ADDR_W-1:0]   ram_address,
  output logic                ram_wren,
  input  logic [MATRIX_W-1:0] ram_q,
  output logic [MATRIX_W-1:0] matrix_a,
  output logic [MATRIX_W-1:0] matrix_b,
  output logic [OP_W-1:0]     alu_op,
  output logic                alu_start,
  input  logic                alu_done,
  output logic                busy,
  output logic                done,
  output logic                error
);

  // Counter reload values: the counter reaches zero on the last cycle of a wait.
  localparam logic [7:0] RD_LOAD = 8'(READ_LATENCY - 1);
  localparam logic [7:0] TO_LOAD = 8'(TIMEOUT - 1);

  state_t              state_q, state_d;
  logic [OP_W-1:0]     op_q, op_d;
  logic [ADDR_W-1:0]   src_a_q, src_a_d;
  logic [ADDR_W-1:0]   src_b_q, src_b_d;
  logic [ADDR_W-1:0]   dst_q, dst_d;
  logic [MATRIX_W-1:0] matrix_a_q, matrix_a_d;
  logic [MATRIX_W-1:0] matrix_b_q, matrix_b_d;
  logic                err_q, err_d;

  logic                accept;
  logic                timeout_hit;
  logic                cnt_load;
  logic [7:0]          cnt_load_value;
  logic                cnt_dec;
  logic                cnt_zero;

  assign accept = (state_q == ST_IDLE) && op_valid;

`ifdef MATRIX_SEQ_TIMEOUT_EN
  // A late alu_done on the final counted cycle still takes the write path.
  assign timeout_hit = (state_q == ST_WAIT_DONE) && !alu_done && cnt_zero;
`else
  assign timeout_hit = 1'b0;
`endif

  seq_wait_counter #(
    .WIDTH(8)
  ) u_wait_counter (
    .clock      (clock),
    .reset      (reset),
    .load       (cnt_load),
    .load_value (cnt_load_value),
    .dec        (cnt_dec),
    .zero       (cnt_zero)
  );

  // State register.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic and wait-counter control.
  always_comb begin
    state_d        = state_q;
    cnt_load       = 1'b0;
    cnt_load_value = RD_LOAD;
    cnt_dec        = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (op_valid) begin
          if (op_is_valid(op_code)) begin
            state_d  = ST_RD_A;
            cnt_load = 1'b1;
          end else begin
            state_d = ST_FINISH;
          end
        end
      end
      ST_RD_A: begin
        if (cnt_zero) begin
          if (op_skips_b(op_q)) begin
            state_d = ST_EXEC;
          end else begin
            state_d  = ST_RD_B;
            cnt_load = 1'b1;
          end
        end else begin
          cnt_dec = 1'b1;
        end
      end
      ST_RD_B: begin
        if (cnt_zero) begin
          state_d = ST_EXEC;
        end else begin
          cnt_dec = 1'b1;
        end
      end
      ST_EXEC: begin
        if (op_q == OP_MUL) begin
          state_d        = ST_WAIT_DONE;
          cnt_load       = 1'b1;
          cnt_load_value = TO_LOAD;
        end else begin
          state_d = ST_WRITE;
        end
      end
      ST_WAIT_DONE: begin
        cnt_dec = 1'b1;
        if (alu_done) begin
          state_d = ST_WRITE;
        end else if (timeout_hit) begin
          state_d = ST_FINISH;
        end
      end
      ST_WRITE:  state_d = ST_FINISH;
      ST_FINISH: state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // Outputs decoded from the current state.
  always_comb begin
    op_ready    = (state_q == ST_IDLE);
    busy        = (state_q != ST_IDLE);
    ram_wren    = (state_q == ST_WRITE);
    alu_start   = (state_q == ST_EXEC) && (op_q == OP_MUL);
    done        = (state_q == ST_FINISH);
    error       = (state_q == ST_FINISH) && err_q;
    ram_address = '0;
    case (state_q)
      ST_RD_A:  ram_address = src_a_q;
      ST_RD_B:  ram_address = src_b_q;
      ST_WRITE: ram_address = dst_q;
      default:  ram_address = '0;
    endcase
  end

  // Request capture, operand latching on the last read cycle, error flag.
  always_comb begin
    op_d       = op_q;
    src_a_d    = src_a_q;
    src_b_d    = src_b_q;
    dst_d      = dst_q;
    matrix_a_d = matrix_a_q;
    matrix_b_d = matrix_b_q;
    err_d      = err_q;
    if (accept) begin
      op_d    = op_code;
      src_a_d = src_a_addr;
      src_b_d = src_b_addr;
      dst_d   = dst_addr;
      err_d   = !op_is_valid(op_code);
    end
    if ((state_q == ST_RD_A) && cnt_zero) begin
      matrix_a_d = ram_q;
    end
    if ((state_q == ST_RD_B) && cnt_zero) begin
      matrix_b_d = ram_q;
    end
    if (timeout_hit) begin
      err_d = 1'b1;
    end
  end

  // Datapath registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      op_q       <= '0;
      src_a_q    <= '0;
      src_b_q    <= '0;
      dst_q      <= '0;
      matrix_a_q <= '0;
      matrix_b_q <= '0;
      err_q      <= 1'b0;
    end else begin
      op_q       <= op_d;
      src_a_q    <= src_a_d;
      src_b_q    <= src_b_d;
      dst_q      <= dst_d;
      matrix_a_q <= matrix_a_d;
      matrix_b_q <= matrix_b_d;
      err_q      <= err_d;
    end
  end

  assign matrix_a = matrix_a_q;
  assign matrix_b = matrix_b_q;
  assign alu_op   = op_q;

endmodule
